// File: rtl/axis_divider.sv
// Fixed-latency pipelined 32-bit signed divider (truncating), valid-only AXI4-Stream channels.
// Stage 0 takes magnitudes, 32 restoring stages, stage 33 fixes signs, then the output register.
module axis_divider (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        s_axis_dividend_tvalid,
  input  logic [31:0] s_axis_dividend_tdata,
  input  logic        s_axis_divisor_tvalid,
  input  logic [31:0] s_axis_divisor_tdata,
  output logic        m_axis_dout_tvalid,
  output logic [63:0] m_axis_dout_tdata
);

  typedef struct packed {
    logic        valid;
    logic        neg_q;
    logic        neg_r;
    logic        dz;
    logic [31:0] dvd;
    logic [31:0] dvs;
    logic [31:0] rem;
    logic [31:0] qd;
  } stage_t;

  stage_t      stg_q [0:32];
  stage_t      stg_d [0:32];
  logic        res_valid_q, res_valid_d;
  logic [63:0] res_data_q, res_data_d;
  logic        out_valid_q, out_valid_d;
  logic [63:0] out_data_q, out_data_d;

  // qd starts as the dividend magnitude and is shifted out MSB-first while quotient bits shift in.
  function automatic stage_t div_step(input stage_t s);
    stage_t      o;
    logic [32:0] t;
    logic [32:0] diff;
    o    = s;
    t    = {s.rem, s.qd[31]};
    diff = t - {1'b0, s.dvs};
    if (!diff[32]) begin
      o.rem = diff[31:0];
      o.qd  = {s.qd[30:0], 1'b1};
    end else begin
      o.rem = t[31:0];
      o.qd  = {s.qd[30:0], 1'b0};
    end
    return o;
  endfunction

  always_comb begin
    stg_d[0]       = '0;
    stg_d[0].valid = s_axis_dividend_tvalid && s_axis_divisor_tvalid;
    stg_d[0].neg_q = s_axis_dividend_tdata[31] ^ s_axis_divisor_tdata[31];
    stg_d[0].neg_r = s_axis_dividend_tdata[31];
    stg_d[0].dz    = (s_axis_divisor_tdata == '0);
    stg_d[0].dvd   = s_axis_dividend_tdata;
    stg_d[0].dvs   = s_axis_divisor_tdata[31] ? (32'd0 - s_axis_divisor_tdata) : s_axis_divisor_tdata;
    stg_d[0].rem   = '0;
    stg_d[0].qd    = s_axis_dividend_tdata[31] ? (32'd0 - s_axis_dividend_tdata) : s_axis_dividend_tdata;
    for (int unsigned k = 1; k <= 32; k++) begin
      stg_d[k] = div_step(stg_q[k-1]);
    end
  end

  // Magnitude of 0x80000000 wraps back to itself, so the overflow case needs no override.
  always_comb begin
    res_valid_d = stg_q[32].valid;
    if (stg_q[32].dz) begin
      res_data_d = {32'hFFFF_FFFF, stg_q[32].dvd};
    end else begin
      res_data_d = {(stg_q[32].neg_q ? (32'd0 - stg_q[32].qd)  : stg_q[32].qd),
                    (stg_q[32].neg_r ? (32'd0 - stg_q[32].rem) : stg_q[32].rem)};
    end
    out_valid_d = res_valid_q;
    out_data_d  = res_valid_q ? res_data_q : out_data_q;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int unsigned k = 0; k <= 32; k++) begin
        stg_q[k] <= '0;
      end
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      for (int unsigned k = 0; k <= 32; k++) begin
        stg_q[k] <= stg_d[k];
      end
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign m_axis_dout_tvalid = out_valid_q;
  assign m_axis_dout_tdata  = out_data_q;

endmodule

// File: tb/tb_axis_divider.sv
// Scoreboard bench for axis_divider: directed vectors with hand-computed results,
// checked for value, order and 34-edge latency by an independent monitor.
module tb_axis_divider;

  logic        aclk;
  logic        aresetn;
  logic        dvd_valid, dvs_valid;
  logic [31:0] dvd_data, dvs_data;
  logic        dout_valid;
  logic [63:0] dout_data;

  axis_divider dut (
    .aclk                   (aclk),
    .aresetn                (aresetn),
    .s_axis_dividend_tvalid (dvd_valid),
    .s_axis_dividend_tdata  (dvd_data),
    .s_axis_divisor_tvalid  (dvs_valid),
    .s_axis_divisor_tdata   (dvs_data),
    .m_axis_dout_tvalid     (dout_valid),
    .m_axis_dout_tdata      (dout_data)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int unsigned cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] data;
    int unsigned edge_n;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [63:0] last_exp = '0;
  logic        mon_en = 1'b0;

  localparam int NV = 19;
  logic [31:0] va [NV];
  logic [31:0] vb [NV];
  logic [63:0] ve [NV];

  initial begin
    va[0]  = 32'd100;        vb[0]  = 32'd7;          ve[0]  = 64'h0000000E_00000002;
    va[1]  = -32'sd100;      vb[1]  = 32'd7;          ve[1]  = 64'hFFFFFFF2_FFFFFFFE;
    va[2]  = 32'd100;        vb[2]  = -32'sd7;        ve[2]  = 64'hFFFFFFF2_00000002;
    va[3]  = -32'sd100;      vb[3]  = -32'sd7;        ve[3]  = 64'h0000000E_FFFFFFFE;
    va[4]  = 32'd5;          vb[4]  = 32'd0;          ve[4]  = 64'hFFFFFFFF_00000005;
    va[5]  = 32'h80000000;   vb[5]  = 32'hFFFFFFFF;   ve[5]  = 64'h80000000_00000000;
    va[6]  = 32'h7FFFFFFF;   vb[6]  = 32'd1;          ve[6]  = 64'h7FFFFFFF_00000000;
    va[7]  = 32'h7FFFFFFF;   vb[7]  = 32'hFFFFFFFF;   ve[7]  = 64'h80000001_00000000;
    va[8]  = 32'h80000000;   vb[8]  = 32'd1;          ve[8]  = 64'h80000000_00000000;
    va[9]  = 32'h80000000;   vb[9]  = 32'd2;          ve[9]  = 64'hC0000000_00000000;
    va[10] = 32'd0;          vb[10] = 32'd5;          ve[10] = 64'h00000000_00000000;
    va[11] = 32'd3;          vb[11] = 32'd7;          ve[11] = 64'h00000000_00000003;
    va[12] = -32'sd3;        vb[12] = 32'd7;          ve[12] = 64'h00000000_FFFFFFFD;
    va[13] = 32'h80000000;   vb[13] = 32'h7FFFFFFF;   ve[13] = 64'hFFFFFFFF_FFFFFFFF;
    va[14] = 32'h7FFFFFFF;   vb[14] = 32'h80000000;   ve[14] = 64'h00000000_7FFFFFFF;
    va[15] = -32'sd5;        vb[15] = 32'd0;          ve[15] = 64'hFFFFFFFF_FFFFFFFB;
    va[16] = 32'd1000;       vb[16] = 32'd10;         ve[16] = 64'h00000064_00000000;
    va[17] = 32'h12345678;   vb[17] = 32'h00000100;   ve[17] = 64'h00123456_00000078;
    va[18] = 32'h80000000;   vb[18] = 32'h80000000;   ve[18] = 64'h00000001_00000000;
  end

  task automatic drive(input logic av, input logic bv, input logic [31:0] a,
                       input logic [31:0] b, input logic [63:0] e, input logic push);
    exp_t x;
    @(negedge aclk);
    dvd_valid = av;
    dvs_valid = bv;
    dvd_data  = a;
    dvs_data  = b;
    if (push) begin
      x.data   = e;
      x.edge_n = cyc + 1;
      sb_q.push_back(x);
    end
  endtask

  task automatic idle(input int n);
    @(negedge aclk);
    dvd_valid = 1'b0;
    dvs_valid = 1'b0;
    dvd_data  = $urandom;
    dvs_data  = $urandom;
    repeat (n - 1) @(negedge aclk);
  endtask

  task automatic drain(input string name);
    int unsigned budget;
    budget = 0;
    while (sb_q.size() != 0 && budget < 200) begin
      @(negedge aclk);
      budget++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d results still pending, required 0", name, sb_q.size());
    end
    idle(3);
  endtask

  // Monitor: compares every presented result against the scoreboard; idle cycles must hold data.
  always @(negedge aclk) begin
    if (mon_en) begin
      if (dout_valid) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result: got %h at edge %0d, required no result", dout_data, cyc);
        end else begin
          exp_t x;
          x = sb_q.pop_front();
          if (dout_data !== x.data || cyc != x.edge_n + 34) begin
            errors++;
            $display("FAIL result: got %h at edge %0d, required %h at edge %0d",
                     dout_data, cyc, x.data, x.edge_n + 34);
          end
          last_exp = x.data;
        end
      end else begin
        checks++;
        if (dout_data !== last_exp) begin
          errors++;
          $display("FAIL hold: tdata %h while idle, required %h", dout_data, last_exp);
        end
      end
    end
  end

  initial begin
    aresetn   = 1'b0;
    dvd_valid = 1'b0;
    dvs_valid = 1'b0;
    dvd_data  = '0;
    dvs_data  = '0;
    #1;
    checks++;
    if (dout_valid !== 1'b0 || dout_data !== 64'd0) begin
      errors++;
      $display("FAIL reset_state: valid=%b data=%h, required 0/0", dout_valid, dout_data);
    end
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    mon_en  = 1'b1;

    // Single isolated pair: one valid cycle, then idle.
    drive(1'b1, 1'b1, va[0], vb[0], ve[0], 1'b1);
    idle(40);
    drain("single");

    // Back-to-back directed stream.
    for (int i = 0; i < NV; i++) drive(1'b1, 1'b1, va[i], vb[i], ve[i], 1'b1);
    idle(1);
    drain("stream");

    // Static inputs held high: continuous stream of the same result.
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, va[17], vb[17], ve[17], 1'b1);
    idle(1);
    drain("static");

    // Half pairs are dropped; neighbours unaffected.
    drive(1'b1, 1'b0, va[2], vb[2], ve[2], 1'b0);
    drive(1'b1, 1'b1, va[3], vb[3], ve[3], 1'b1);
    drive(1'b0, 1'b1, va[4], vb[4], ve[4], 1'b0);
    drive(1'b1, 1'b1, va[13], vb[13], ve[13], 1'b1);
    idle(1);
    drain("handshake");

    // Reset mid-flight: in-flight results vanish; output clears at once.
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, va[i], vb[i], ve[i], 1'b0);
    idle(10);
    @(posedge aclk);
    #2;
    aresetn  = 1'b0;
    last_exp = '0;
    #1;
    checks++;
    if (dout_valid !== 1'b0 || dout_data !== 64'd0) begin
      errors++;
      $display("FAIL async_reset: valid=%b data=%h, required 0/0", dout_valid, dout_data);
    end
    @(negedge aclk);
    aresetn = 1'b1;
    idle(45);
    drive(1'b1, 1'b1, va[15], vb[15], ve[15], 1'b1);
    idle(1);
    drain("after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_divider.md
# axis_divider

Fixed-latency, fully pipelined 32-bit signed integer divider with AXI4-Stream-style valid-only operand and result channels. It is the arithmetic core behind the pipeline's divide functional unit. That unit reads the quotient from the upper half of the 64-bit result word. The block accepts one operand pair per cycle and has no backpressure.

## Interface
- No parameters. Widths are fixed at 32-bit operands and a 64-bit result.
- aclk  in  1  clock; all state updates on the rising edge.
- aresetn  in  1  asynchronous, active-low reset.
- s_axis_dividend_tvalid  in  1  dividend present this cycle.
- s_axis_dividend_tdata  in  32  dividend, two's complement.
- s_axis_divisor_tvalid  in  1  divisor present this cycle.
- s_axis_divisor_tdata  in  32  divisor, two's complement.
- m_axis_dout_tvalid  out  1  result word valid this cycle.
- m_axis_dout_tdata  out  64  {quotient[31:0], remainder[31:0]}; quotient in bits 63:32, remainder in bits 31:0.

## Operation
- Operand acceptance:
  - A pair is accepted on a rising edge when both tvalid inputs are high.
  - If only one tvalid is high, nothing is accepted and that operand is dropped; there is no per-channel buffering.
  - There is no tready; the block is always ready.
- Arithmetic (signed, truncating toward zero):
  - quotient = trunc(dividend / divisor).
  - remainder = dividend − quotient × divisor, so the remainder takes the sign of the dividend and |remainder| < |divisor|.
- Divide by zero: quotient = 0xFFFFFFFF, remainder = dividend. No error flag.
- Overflow case 0x80000000 / 0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
- Datapath structure, with each stage carrying a valid bit alongside its data:
  - stage 0 registers the operands and computes magnitudes and result signs;
  - stages 1–32 each perform one radix-2 restoring or non-restoring step on the unsigned magnitudes;
  - stage 33 applies the sign correction and the special-case overrides.
- Results leave in acceptance order; every accepted pair produces exactly one result.
- No bubbles are inserted. Consecutive accepted pairs produce results on consecutive cycles.

## Timing
- Reset:
  - While aresetn = 0, all pipeline valid bits are cleared, m_axis_dout_tvalid = 0 and m_axis_dout_tdata = 0.
  - Reset takes effect immediately (asynchronous).
  - Release is sampled synchronously; the first acceptance can happen on the first rising edge with aresetn = 1.
- Latency:
  - A pair accepted on rising edge E drives m_axis_dout_tvalid = 1 and the corresponding tdata after rising edge E+34.
  - The result holds for exactly one cycle unless the next result follows.
- Throughput: one result per cycle. Inputs asserted on N consecutive edges give N consecutive valid output cycles starting 34 edges after the first.
- Valid and data pairing:
  - m_axis_dout_tvalid is 0 on every cycle that carries no accepted result.
  - m_axis_dout_tdata holds its last value when tvalid = 0.
- Reset mid-operation: all in-flight results are discarded. No m_axis_dout_tvalid pulse occurs for operands accepted before the reset.
- Static inputs: holding both tvalid high with constant tdata is a new acceptance every cycle, so after fill the output shows a continuous valid stream of the same result.

## Test plan
- 100 / 7 accepted at edge E → after edge E+34, tvalid = 1 and tdata = 0x0000000E_00000002. tvalid = 0 the following cycle.
- −100 / 7 → tdata = 0xFFFFFFF2_FFFFFFFE. Also 100 / −7 → 0xFFFFFFF2_00000002.
- 5 / 0 → tdata = 0xFFFFFFFF_00000005. 0x80000000 / 0xFFFFFFFF → tdata = 0x80000000_00000000.
- Back-to-back stream: 1000 random signed pairs presented on consecutive edges, including divisor ±1 and operands 0x7FFFFFFF and 0x80000000.
  - Results arrive on consecutive cycles, in order.
  - Every result matches the reference model (truncating quotient, remainder sign = dividend).
- Handshake: pair with dividend_tvalid = 1 and divisor_tvalid = 0 → no result is ever produced; the next full pair is unaffected.
- Reset mid-flight: accept 3 pairs, then pulse aresetn low for 1 cycle at edge E+10.
  - tvalid drops immediately and no stale result appears.
  - A new pair accepted after release returns correctly 34 edges later.
